// File: rtl/dsp_pkg.sv
// dsp_pkg: shared Q-format constants and divider state encoding for the DSP datapath
package dsp_pkg;
  localparam int DSP_WIDTH = 16;
  localparam int Q_FRAC = DSP_WIDTH - 1;
  localparam logic [DSP_WIDTH-1:0] Q_MAX = {1'b0, {Q_FRAC{1'b1}}};
  localparam logic [DSP_WIDTH-1:0] Q_MIN = {1'b1, {Q_FRAC{1'b0}}};
  typedef enum logic [1:0] {IDLE, ITER, ROUND} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step yielding a quotient bit and the new remainder
module div_step #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH:0] rem,
  input  logic [BIT_WIDTH:0] divisor,
  input  logic               next_bit,
  output logic [BIT_WIDTH:0] rem_next,
  output logic               q_bit
);
  logic [BIT_WIDTH+1:0] shifted;
  always_comb begin
    shifted = {rem, next_bit};
    q_bit = shifted >= {1'b0, divisor};
    rem_next = q_bit ? (BIT_WIDTH+1)'(shifted - {1'b0, divisor}) : shifted[BIT_WIDTH:0];
  end
endmodule

// File: rtl/fixed_divide.sv
// fixed_divide: sequential signed Q1.15 divider, half-up rounding, saturating, start/done handshake
module fixed_divide
  import dsp_pkg::*;
#(
  parameter int BIT_WIDTH = DSP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic [BIT_WIDTH-1:0] quotient,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 div_by_zero
);
  localparam int CW = $clog2(BIT_WIDTH);
  localparam logic [BIT_WIDTH-1:0] SAT_POS = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] SAT_NEG = ~SAT_POS;
  div_state_t state;
  logic sign, zero, sat, q_bit, clamp, accept;
  logic [BIT_WIDTH:0] a_ext, b_ext, a_abs, b_abs, b_mag, rem, rem_next;
  logic [BIT_WIDTH-1:0] raw, mag, result;
  logic [CW-1:0] count;
  // |a| < |b| whenever the result is not overridden, so |a| preloads the
  // remainder and only the zero fraction/guard tail is shifted in.
  div_step #(.BIT_WIDTH(BIT_WIDTH)) u_step (
    .rem(rem), .divisor(b_mag), .next_bit(1'b0), .rem_next(rem_next), .q_bit(q_bit)
  );
  always_comb begin
    a_ext = {a[BIT_WIDTH-1], a};
    b_ext = {b[BIT_WIDTH-1], b};
    a_abs = a[BIT_WIDTH-1] ? -a_ext : a_ext;
    b_abs = b[BIT_WIDTH-1] ? -b_ext : b_ext;
    accept = start && !busy;
    mag = {1'b0, raw[BIT_WIDTH-1:1]} + BIT_WIDTH'(raw[0]);
    clamp = !sign && mag == SAT_NEG;
    result = (zero || sat || clamp) ? (sign ? SAT_NEG : SAT_POS) : sign ? -mag : mag;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      quotient <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
      sign <= 1'b0;
      zero <= 1'b0;
      sat <= 1'b0;
      b_mag <= '0;
      rem <= '0;
      raw <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= accept;
          if (accept) begin
            sign <= a[BIT_WIDTH-1] ^ b[BIT_WIDTH-1];
            zero <= b == '0;
            sat <= a_abs >= b_abs;
            b_mag <= b_abs;
            rem <= a_abs;
            raw <= '0;
            count <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          rem <= rem_next;
          raw <= {raw[BIT_WIDTH-2:0], q_bit};
          count <= count + 1'b1;
          state <= count == CW'(BIT_WIDTH-1) ? ROUND : ITER;
        end
        ROUND: begin
          quotient <= result;
          overflow <= !zero && (sat || clamp);
          div_by_zero <= zero;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_divide.sv
// tb_fixed_divide: scoreboard bench for fixed_divide against an arithmetic Q1.15 reference model
module tb_fixed_divide;
  import dsp_pkg::*;
  logic clk = 0, reset_n = 0, start = 0;
  logic [15:0] a = 0, b = 0, quotient;
  logic done, busy, overflow, div_by_zero;
  typedef struct {logic [15:0] q; logic ovf; logic dz; int acc;} exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0, cyc = 0;
  logic prev_done = 0;

  fixed_divide #(.BIT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .quotient(quotient), .done(done), .busy(busy), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Reference: quotient = |a|/|b| scaled by 2^15, rounded half-up, signed and saturated.
  function automatic exp_t model(logic [15:0] x, logic [15:0] y, int acc);
    exp_t e;
    int sa, sy, ma, mb;
    bit neg;
    longint r;
    sa = $signed(x);
    sy = $signed(y);
    ma = sa < 0 ? -sa : sa;
    mb = sy < 0 ? -sy : sy;
    neg = (sa < 0) != (sy < 0);
    e.acc = acc;
    e.ovf = 0;
    e.dz = 0;
    if (sy == 0) begin
      e.dz = 1;
      e.q = sa < 0 ? Q_MIN : Q_MAX;
    end else if (ma >= mb) begin
      e.ovf = 1;
      e.q = neg ? Q_MIN : Q_MAX;
    end else begin
      r = ((longint'(ma) * 65536) / mb + 1) / 2;
      if (r == 32768 && !neg) begin
        e.ovf = 1;
        e.q = Q_MAX;
      end else e.q = neg ? 16'(-r) : 16'(r);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse", int'(prev_done), 0);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("overflow", overflow, e.ovf);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("latency_edges", cyc - e.acc, 17);
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_wait", busy, 0);
  endtask

  task automatic issue(logic [15:0] x, logic [15:0] y);
    wait_idle();
    start = 1;
    a = x;
    b = y;
    sb.push_back(model(x, y, cyc + 1));
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 0;
      a = 16'($urandom);
      b = 16'($urandom);
      chk("busy_run", busy, 1);
      if (k >= 17) chk("done_timing", done, k == 18);
    end
    @(negedge clk);
    chk("busy_clear", busy, 0);
  endtask

  logic [15:0] da[12] = '{16'h2000, 16'h0001, 16'h1000, 16'hE000, 16'hE000, 16'hC000,
                          16'h4000, 16'h8000, 16'h0000, 16'h8000, 16'h0001, 16'h7FFF};
  logic [15:0] db[12] = '{16'h4000, 16'h0003, 16'h6000, 16'h4000, 16'hC000, 16'h4000,
                          16'h2000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000};

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] x, y;
    repeat (2) @(negedge clk);
    chk("reset_quotient", quotient, 0);
    chk("reset_flags", {done, busy, overflow, div_by_zero}, 0);
    reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) issue(da[i], db[i]);
    for (int i = 0; i < 30; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 1) == 1) x = 16'($signed(x) >>> $urandom_range(1, 8));
      if ($urandom_range(0, 9) == 0) y = 0;
      issue(x, y);
    end
    wait_idle();
    start = 1;
    for (int i = 0; i < 58; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 19 == 0) sb.push_back(model(a, b, cyc + 1));
      @(negedge clk);
    end
    start = 0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("held_start_drain", sb.size(), 0);
    issue(16'h1000, 16'h6000);
    wait_idle();
    start = 1;
    a = 16'h2000;
    b = 16'h4000;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    reset_n = 0;
    void'(sb.pop_back());
    #1;
    chk("abort_quotient", quotient, 0);
    chk("abort_flags", {done, busy, overflow, div_by_zero}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", {done, busy}, 0);
    end
    reset_n = 1;
    @(negedge clk);
    issue(16'h2000, 16'h4000);
    repeat (25) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
